// File: rtl/max_pool_2x2_layer.sv
// 2x2 stride-2 max pooling over convolved float rows: the even row of a pair is
// buffered, and the odd row drives a two-stage vertical-then-horizontal max pipeline.
module max_pool_2x2_layer #(
  parameter int ARRAY_SIZE = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WIDTH  = 3,
  parameter int IDX_WIDTH  = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   feature_in,
  input  logic [IDX_WIDTH-1:0]               feature_idx,
  input  logic [ROW_WIDTH-1:0]               feature_row,
  input  logic                               image_calc_fin,
  output logic                               out_valid,
  output logic [ARRAY_SIZE/2*DATA_WIDTH-1:0] pool_out,
  output logic [IDX_WIDTH-1:0]               pool_idx,
  output logic [ROW_WIDTH-1:0]               pool_row,
  output logic                               pool_fin,
  output logic                               row_err
);

  localparam int OUT_SIZE = ARRAY_SIZE / 2;
  localparam int IN_W     = ARRAY_SIZE * DATA_WIDTH;
  localparam int OUT_W    = OUT_SIZE * DATA_WIDTH;

  // Handshake: no backpressure. A row is consumed in every cycle in_valid is high,
  // and out_valid qualifies pool_out/pool_idx/pool_row for exactly that cycle.

  // Float max for finite operands; ties keep a, and +0 beats -0 via the sign test.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic sa;
    logic sb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    if (sa != sb)
      fmax = sa ? b : a;
    else if (!sa)
      fmax = (b > a) ? b : a;
    else
      fmax = (b < a) ? b : a;
  endfunction

  logic [IN_W-1:0]      buf_data;
  logic [IDX_WIDTH-1:0] buf_idx;
  logic [ROW_WIDTH-1:0] buf_row;
  logic                 buf_valid;

  logic                 s1_valid;
  logic [IN_W-1:0]      s1_vmax;
  logic [IDX_WIDTH-1:0] s1_idx;
  logic [ROW_WIDTH-1:0] s1_row;

  logic                 fin_latch;

  logic                 even_row;
  logic                 odd_row;
  logic [ROW_WIDTH-1:0] prev_row;
  logic                 pair_match;
  logic                 pair_fire;
  logic [IN_W-1:0]      vmax_c;
  logic [OUT_W-1:0]     pooled_c;

  assign even_row   = in_valid & ~feature_row[0];
  assign odd_row    = in_valid &  feature_row[0];
  assign prev_row   = feature_row - ROW_WIDTH'(1);
  assign pair_match = buf_valid && (buf_idx == feature_idx) && (buf_row == prev_row);
  assign pair_fire  = odd_row & pair_match;

  // Buffer and incoming row share the word-0-in-MSBs layout, so slices line up.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_vmax
    assign vmax_c[i*DATA_WIDTH +: DATA_WIDTH] =
      fmax(buf_data[i*DATA_WIDTH +: DATA_WIDTH], feature_in[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  for (genvar j = 0; j < OUT_SIZE; j++) begin : g_hmax
    assign pooled_c[(OUT_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH] =
      fmax(s1_vmax[(ARRAY_SIZE-1-2*j)*DATA_WIDTH +: DATA_WIDTH],
           s1_vmax[(ARRAY_SIZE-2-2*j)*DATA_WIDTH +: DATA_WIDTH]);
  end

  assign pool_fin = fin_latch & ~s1_valid & ~out_valid;

  // Even-row buffer; a new even row takes precedence over the fin-time flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data  <= '0;
      buf_idx   <= '0;
      buf_row   <= '0;
      buf_valid <= 1'b0;
    end else if (even_row) begin
      buf_data  <= feature_in;
      buf_idx   <= feature_idx;
      buf_row   <= feature_row;
      buf_valid <= 1'b1;
    end else if (odd_row || pool_fin) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_vmax  <= '0;
      s1_idx   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= pair_fire;
      if (pair_fire) begin
        s1_vmax <= vmax_c;
        s1_idx  <= feature_idx;
        s1_row  <= feature_row >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pool_out  <= '0;
      pool_idx  <= '0;
      pool_row  <= '0;
    end else begin
      out_valid <= s1_valid;
      pool_out  <= s1_valid ? pooled_c : '0;
      pool_idx  <= s1_valid ? s1_idx   : '0;
      pool_row  <= s1_valid ? s1_row   : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_err   <= 1'b0;
      fin_latch <= 1'b0;
    end else begin
      if (odd_row && !pair_match)
        row_err <= 1'b1;
      if (image_calc_fin)
        fin_latch <= 1'b1;
      else if (pool_fin)
        fin_latch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_max_pool_2x2_layer.sv
// Bench for max_pool_2x2_layer: directed corner rows plus random images, checked
// against a real-valued reference model through an expected-output queue.
module tb_max_pool_2x2_layer;

  localparam int N  = 6;
  localparam int DW = 32;
  localparam int RW = 3;
  localparam int IW = 2;
  localparam int M  = N / 2;
  localparam int EW = M*DW + IW + RW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [N*DW-1:0]   feature_in = '0;
  logic [IW-1:0]     feature_idx = '0;
  logic [RW-1:0]     feature_row = '0;
  logic              image_calc_fin = 1'b0;
  logic              out_valid;
  logic [M*DW-1:0]   pool_out;
  logic [IW-1:0]     pool_idx;
  logic [RW-1:0]     pool_row;
  logic              pool_fin;
  logic              row_err;

  max_pool_2x2_layer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .feature_in(feature_in),
    .feature_idx(feature_idx), .feature_row(feature_row),
    .image_calc_fin(image_calc_fin), .out_valid(out_valid), .pool_out(pool_out),
    .pool_idx(pool_idx), .pool_row(pool_row), .pool_fin(pool_fin), .row_err(row_err)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;
  int fin_cnt = 0;
  int out_cnt = 0;

  logic [EW-1:0] exp_q[$];
  int            due_q[$];

  // Reference model state: last even row, sticky error, pending fin.
  logic [DW-1:0] mb[N];
  logic [DW-1:0] win[N];
  logic [IW-1:0] m_idx;
  logic [RW-1:0] m_row;
  logic [RW-1:0] m_prev;
  logic [M*DW-1:0] m_res;
  bit m_val = 1'b0;
  bit m_err = 1'b0;
  bit m_fin_pend = 1'b0;
  bit fin_fire = 1'b0;
  logic [M*DW-1:0] last_out = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real to_real(input logic [DW-1:0] w);
    real v;
    int e;
    e = int'(w[30:23]);
    if (e == 0) return 0.0;
    v = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (real'(e) - 127.0));
    return w[31] ? -v : v;
  endfunction

  // Max of a 2x2 window by numeric value; the only equal-value/different-bit case is +-0.
  function automatic logic [DW-1:0] ref_max4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0] w[4];
    logic [DW-1:0] best;
    real bv;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    best = w[0];
    bv = to_real(best);
    for (int k = 1; k < 4; k++) begin
      if (to_real(w[k]) > bv) begin
        best = w[k];
        bv = to_real(w[k]);
      end
    end
    if (bv == 0.0)
      best = (a == 0 || b == 0 || c == 0 || d == 0) ? 32'h0000_0000 : 32'h8000_0000;
    return best;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] tbl[4];
    tbl[0] = 32'h3F80_0000; tbl[1] = 32'hBF80_0000;
    tbl[2] = 32'h4000_0000; tbl[3] = 32'hC000_0000;
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2, 3:    return tbl[$urandom_range(0, 3)];
      default: return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endcase
  endfunction

  function automatic logic [N*DW-1:0] rand_row();
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[(N-1-i)*DW +: DW] = rand_word();
    return r;
  endfunction

  // Model: consumes the bench's own stimulus at each sampling edge.
  always @(posedge clk) begin
    if (rst) begin
      m_val = 1'b0;
      m_err = 1'b0;
      m_fin_pend = 1'b0;
      exp_q.delete();
      due_q.delete();
    end else begin
      if (in_valid) begin
        for (int i = 0; i < N; i++) win[i] = feature_in[(N-1-i)*DW +: DW];
        if (!feature_row[0]) begin
          mb = win;
          m_idx = feature_idx;
          m_row = feature_row;
          m_val = 1'b1;
        end else begin
          m_prev = feature_row - 3'd1;
          if (m_val && m_idx == feature_idx && m_row == m_prev) begin
            for (int j = 0; j < M; j++)
              m_res[(M-1-j)*DW +: DW] = ref_max4(mb[2*j], mb[2*j+1], win[2*j], win[2*j+1]);
            exp_q.push_back({m_res, feature_idx, feature_row >> 1});
            due_q.push_back(cyc + 2);
          end else begin
            m_err = 1'b1;
          end
          m_val = 1'b0;
        end
      end
      if (fin_fire && !(in_valid && !feature_row[0])) m_val = 1'b0;
      if (image_calc_fin) m_fin_pend = 1'b1;
      else if (fin_fire) m_fin_pend = 1'b0;
    end
    cyc++;
  end

  // Monitor: compares the DUT outputs each cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      bit occ;
      bit exp_fin;
      occ = 1'b0;
      foreach (due_q[k]) if (due_q[k] == cyc || due_q[k] == cyc + 1) occ = 1'b1;
      exp_fin = m_fin_pend && !occ;
      check("pool_fin", 128'(pool_fin), 128'(exp_fin));
      fin_fire = exp_fin;
      if (pool_fin) fin_cnt++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        check("out_valid", 128'(out_valid), 128'(1));
        check("pooled_row", 128'({pool_out, pool_idx, pool_row}), 128'(exp_q[0]));
        last_out = pool_out;
        out_cnt++;
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        check("idle_out", 128'({out_valid, pool_out, pool_idx, pool_row}), 128'(0));
      end
      check("row_err", 128'(row_err), 128'(m_err));
    end else begin
      fin_fire = 1'b0;
    end
  end

  task automatic send(input logic [N*DW-1:0] d, input int idx, input int row, input bit fin);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    feature_in = d;
    feature_idx = IW'(idx);
    feature_row = RW'(row);
    image_calc_fin = fin;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      image_calc_fin = 1'b0;
      feature_in = '0;
    end
  endtask

  task automatic pulse_fin();
    @(negedge clk);
    in_valid = 1'b0;
    image_calc_fin = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    image_calc_fin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("reset_outputs", 128'({out_valid, pool_out, pool_idx, pool_row, pool_fin, row_err}), 128'(0));
  endtask

  initial begin
    int nrows;
    int idx;
    int row;
    int fcnt0;
    int ocnt0;
    bit fin_sent;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    check("reset_outputs", 128'({out_valid, pool_out, pool_idx, pool_row, pool_fin, row_err}), 128'(0));

    // Basic pair.
    last_out = '0;
    send({32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'hC000_0000, 32'h3F00_0000, 32'h4040_0000}, 0, 0, 0);
    send({32'h3F00_0000, 32'h4040_0000, 32'hC000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h4000_0000}, 0, 1, 0);
    idle(4);
    check("basic_pair", 128'(last_out), 128'({32'h4040_0000, 32'hBF80_0000, 32'h4040_0000}));

    // Signed zero and negative corners.
    last_out = '1;
    send({32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000}, 2, 2, 0);
    send({32'h0000_0000, 32'h8000_0000, 32'hC000_0000, 32'hC000_0000, 32'h8000_0000, 32'h3F80_0000}, 2, 3, 0);
    idle(4);
    check("zero_corner", 128'(last_out), 128'({32'h0000_0000, 32'hBF80_0000, 32'h3F80_0000}));

    // Back-to-back rows 0..5.
    ocnt0 = out_cnt;
    for (int r = 0; r < 6; r++) send(rand_row(), 1, r, 0);
    idle(5);
    check("b2b_count", 128'(out_cnt - ocnt0), 128'(3));

    // Mismatched rows raise a sticky error.
    send(rand_row(), 2, 0, 0);
    send(rand_row(), 2, 3, 0);
    idle(3);
    check("err_set", 128'(row_err), 128'(1));
    send(rand_row(), 1, 0, 0);
    send(rand_row(), 2, 1, 0);
    idle(6);
    check("err_sticky", 128'(row_err), 128'(1));
    do_reset();

    // fin coincides with the last odd row.
    fcnt0 = fin_cnt;
    for (int r = 0; r < 3; r++) send(rand_row(), 3, r, 0);
    send(rand_row(), 3, 3, 1);
    idle(6);
    check("fin_once", 128'(fin_cnt - fcnt0), 128'(1));

    // Reset right after a matched odd row drops it.
    ocnt0 = out_cnt;
    send(rand_row(), 0, 0, 0);
    send(rand_row(), 0, 1, 0);
    do_reset();
    idle(3);
    check("reset_drop", 128'(out_cnt - ocnt0), 128'(0));
    last_out = '0;
    send({32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'hC000_0000, 32'h3F00_0000, 32'h4040_0000}, 0, 0, 0);
    send({32'h3F00_0000, 32'h4040_0000, 32'hC000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h4000_0000}, 0, 1, 0);
    idle(4);
    check("after_reset_pair", 128'(last_out), 128'({32'h4040_0000, 32'hBF80_0000, 32'h4040_0000}));

    // Random images.
    for (int img = 0; img < 60; img++) begin
      idx = $urandom_range(0, 3);
      nrows = $urandom_range(1, 6);
      fin_sent = 1'b0;
      for (int r = 0; r < nrows; r++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        row = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : r;
        if (r == nrows - 1 && $urandom_range(0, 1) == 1) begin
          send(rand_row(), idx, row, 1);
          fin_sent = 1'b1;
        end else begin
          send(rand_row(), idx, row, 0);
        end
      end
      idle($urandom_range(0, 4));
      if (!fin_sent) pulse_fin();
      idle($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    idle(8);
    check("drain", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2_layer.md
Name: max_pool_2x2_layer

Overview:
Downstream stage of the convolution layer top. Consumes convolved feature rows (ARRAY_SIZE IEEE-754 single-precision words per row, tagged with feature index and row number). Performs 2x2 stride-2 max pooling and emits pooled rows of ARRAY_SIZE/2 words for the next layer. Buffers one even row per feature map, then produces the pooled output through a 2-stage pipeline.

Parameters:
ARRAY_SIZE, 6, words per input feature row; must be even
DATA_WIDTH, 32, word width (IEEE-754 single)
ROW_WIDTH, 3, width of row index
IDX_WIDTH, 2, width of feature map index

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in_valid  input  1  feature_in holds a complete convolved row this cycle
feature_in  input  ARRAY_SIZE*DATA_WIDTH  row data; word 0 in the MSBs
feature_idx  input  IDX_WIDTH  feature map index of the row
feature_row  input  ROW_WIDTH  row number within the feature map
image_calc_fin  input  1  single-cycle pulse: upstream finished the image
out_valid  output  1  pool_out holds a pooled row
pool_out  output  ARRAY_SIZE/2*DATA_WIDTH  pooled row; word 0 in the MSBs; zero when out_valid=0
pool_idx  output  IDX_WIDTH  feature index of pool_out
pool_row  output  ROW_WIDTH  pooled row number (feature_row>>1)
pool_fin  output  1  single-cycle pulse: all pooled rows of the image delivered
row_err  output  1  sticky: odd row arrived without a matching buffered even row

Behaviour:
- Reset (rst=1 at a clk edge) clears the even-row buffer, buffer-valid flag, pipeline valids, fin latch and row_err. All outputs are 0 the cycle after reset. Reset mid-operation discards any in-flight row; no output is produced for it.
- Float max rule, per word pair a,b (NaN/Inf are not supported):
  - signs differ: the positive operand wins;
  - both positive: the larger unsigned bits win;
  - both negative: the smaller unsigned bits win;
  - +0 beats -0; equal bits return a.
- Even row (feature_row[0]=0, in_valid=1): store feature_in, feature_idx and feature_row in the buffer and set buf_valid. If buf_valid was already set, overwrite silently; the older row is dropped.
- Odd row (feature_row[0]=1, in_valid=1):
  - Matched when buf_valid=1, buf_idx==feature_idx and buf_row==feature_row-1.
  - Stage 1 (registered): vmax[i] = max(buf[i], in[i]) for every word. Clear buf_valid.
  - Unmatched: set row_err, produce no output, clear buf_valid.
- Stage 2 (registered): pool_out[j] = max(vmax[2j], vmax[2j+1]) for j = 0..ARRAY_SIZE/2-1. Asserts out_valid with pool_idx and pool_row=feature_row>>1.
- Latency: out_valid is high exactly 2 cycles after the matched odd-row in_valid cycle, for one cycle. Fully pipelined: one row per cycle is accepted.
- An odd row also forms a valid even/odd sequence only with its own buffer. Upstream row order 0,1,2,3,... is required. A trailing even row with no odd partner (odd row count) stays buffered and is discarded at pool_fin.
- image_calc_fin: latched. pool_fin pulses the first cycle in which the latch is set and both pipeline stages are empty, including when fin and the last odd row coincide. The same event clears the latch and buf_valid.
- A simultaneous in_valid with image_calc_fin is processed normally before fin takes effect.

Test Plan:
- Single block, ARRAY_SIZE=6. Row0 = {1.0,2.0,-1.0,-2.0,0.5,3.0} (0x3F800000,0x40000000,0xBF800000,0xC0000000,0x3F000000,0x40400000), row1 = {0.5,3.0,-2.0,-1.0,1.0,2.0}, idx 0 -> exactly 2 cycles after row1: out_valid=1, pool_out={0x40400000,0xBF800000,0x40400000}, pool_row=0.
- Sign/zero corners: pair -0.0(0x80000000) vs +0.0, and -2.0 vs -1.0 in the same window -> winners 0x00000000 and 0xBF800000.
- Back-to-back rows 0..5 on consecutive cycles, idx 1 -> three out_valid pulses at cycles t1+2, t3+2, t5+2 with pool_row 0,1,2 and pool_idx 1.
- Odd row 3 arrives with buffered row 0 (or idx mismatch) -> no out_valid; row_err=1 and stays 1 until rst.
- image_calc_fin asserted in the same cycle as the last odd row -> out_valid 2 cycles later, then pool_fin pulse the following cycle, exactly one cycle wide.
- rst asserted one cycle after a matched odd row -> no out_valid appears; all outputs 0 next cycle; a fresh row0/row1 pair then pools correctly.
